ls_sequencer: RTL

- Multi-cycle load/store control sequencer for the LEGv8 datapath.
- Latches an instruction on `start`, decodes the D-format load/store opcodes, and drives the 36-bit datapath control word through address, memory-wait and writeback phases.
- Replaces the fixed one/two-state scheme with a variable-latency memory handshake, a timeout, and word and signed-word variants.
- Sits beside the other per-class control units; the top-level control mux selects its `controlWord` while `busy`=1.

---
 rtl/ls_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ls_sequencer.sv
// LEGv8 load/store control sequencer.
// Multi-cycle D-format load/store with memory handshake and timeout.
module ls_sequencer #(
  parameter int CUL     = 35,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [31:0]  IR,
  input  logic         mem_ready,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         sext,
  output logic [2:0]   k_mux,
  output logic [CUL:0] controlWord
);

  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_WB,
    S_ERR
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       load;
    logic [1:0] size;
    logic       sext;
  } dec_t;

  typedef struct packed {
    logic [4:0] fs;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] da;
    logic       w_reg;
    logic       c0;
    logic [1:0] mem_cs;
    logic       b_sel;
    logic       mem_we;
    logic       ir_load;
    logic       status_load;
    logic [1:0] size;
    logic       add_tri;
    logic [1:0] data_tri;
    logic       pc_sel;
    logic [1:0] pc_fs;
  } cw_t;

  function automatic dec_t decode(input logic [10:0] op);
    dec_t d;
    d = '0;
    case (op)
      11'b00111000000: d = '{1'b1, 1'b0, 2'b00, 1'b0};
      11'b01111000000: d = '{1'b1, 1'b0, 2'b01, 1'b0};
      11'b10111000000: d = '{1'b1, 1'b0, 2'b10, 1'b0};
      11'b11111000000: d = '{1'b1, 1'b0, 2'b11, 1'b0};
      11'b00111000010: d = '{1'b1, 1'b1, 2'b00, 1'b0};
      11'b01111000010: d = '{1'b1, 1'b1, 2'b01, 1'b0};
      11'b10111000100: d = '{1'b1, 1'b1, 2'b10, 1'b1};
      11'b11111000010: d = '{1'b1, 1'b1, 2'b11, 1'b0};
      default:         d = '0;
    endcase
    return d;
  endfunction

  state_t           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  dec_t dec_in;
  dec_t dec_q;
  cw_t  cw;

  logic unused_ir;

  assign dec_in    = decode(IR[31:21]);
  assign dec_q     = decode(ir_q[31:21]);
  assign unused_ir = ^ir_q[20:10];

  // Next-state and control-word generation from state and handshake.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    cw      = '0;
    busy    = 1'b0;
    done    = 1'b0;
    error   = 1'b0;
    sext    = 1'b0;
    k_mux   = 3'b000;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ir_d    = IR;
          cnt_d   = '0;
          state_d = dec_in.legal ? S_ADDR : S_ERR;
        end
      end
      S_ADDR, S_WAIT: begin
        busy        = 1'b1;
        k_mux       = 3'b001;
        cw.fs       = 5'b01000;
        cw.sa       = ir_q[9:5];
        cw.sb       = ir_q[4:0];
        cw.b_sel    = 1'b1;
        cw.mem_cs   = 2'b01;
        cw.size     = dec_q.size;
        cw.mem_we   = ~dec_q.load;
        cw.data_tri = dec_q.load ? 2'b11 : 2'b01;
        if (mem_ready) begin
          if (dec_q.load) begin
            state_d = S_WB;
          end else begin
            done     = 1'b1;
            cw.pc_fs = 2'b01;
            state_d  = S_IDLE;
          end
        end else if (cnt_q == T_LAST) begin
          // Abort: drop the write strobe so memory sees no store.
          done      = 1'b1;
          error     = 1'b1;
          cw.mem_we = 1'b0;
          state_d   = S_IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WB: begin
        busy        = 1'b1;
        k_mux       = 3'b001;
        cw.w_reg    = 1'b1;
        cw.da       = ir_q[4:0];
        cw.data_tri = 2'b11;
        cw.mem_cs   = 2'b01;
        cw.size     = dec_q.size;
        cw.pc_fs    = 2'b01;
        done        = 1'b1;
        sext        = dec_q.sext;
        state_d     = S_IDLE;
      end
      S_ERR: begin
        busy    = 1'b1;
        k_mux   = 3'b001;
        done    = 1'b1;
        error   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign controlWord = cw;

  // State, latched instruction and wait counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
